// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem req/ack handshake,
// registers the returned word for decode, and handles redirects and stalls.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCsrc,
  input  logic [31:0] PCalu,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcout_q, pcout_d;
  logic        iv_q, iv_d;
  logic        req;

  // Request is combinational so a zero-wait memory can ack in the request cycle;
  // it is suppressed by reset, a redirect, or a held instruction under stall.
  always_comb begin
    req = (state_q == FETCH) && !rst && !PCsrc && !(iv_q && stall);
  end

  // Next-state and datapath update; a redirect overrides stall and any ack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pcout_d = pcout_q;
    iv_d    = iv_q;
    if (PCsrc) begin
      pc_d    = PCalu;
      iv_d    = 1'b0;
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (iv_q && stall) begin
            state_d = HOLD;
          end else if (req && imem_ack) begin
            inst_d  = imem_rdata;
            pcout_d = pc_q;
            iv_d    = 1'b1;
            pc_d    = pc_q + PC_STEP;
          end else begin
            // Previous instruction consumed by decode and nothing new arrived.
            iv_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            // Decode takes the held instruction this cycle.
            iv_d    = 1'b0;
            state_d = FETCH;
          end
        end
        FLUSH: begin
          iv_d    = 1'b0;
          state_d = FETCH;
        end
        default: begin
          iv_d    = 1'b0;
          state_d = FETCH;
        end
      endcase
    end
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      pcout_q <= 32'h0;
      iv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pcout_q <= pcout_d;
      iv_q    <= iv_d;
    end
  end

  assign imem_req   = req;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = iv_q;
  assign pc_out     = pcout_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: cycle-by-cycle vector table on a RESET_PC=0
// instance, plus a hand sequence on a wrap-around RESET_PC instance.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default RESET_PC
  logic        rst, pcsrc, stall, ack, req, iv;
  logic [31:0] pcalu, addr, rdata, inst, pco;

  // Instance 1: RESET_PC near the top of the address space
  logic        d1_rst, d1_pcsrc, d1_stall, d1_ack, d1_req, d1_iv;
  logic [31:0] d1_pcalu, d1_addr, d1_rdata, d1_inst, d1_pco;

  // Memory returns a word derived from the address so each fetch is traceable.
  assign rdata    = 32'hC000_0000 ^ addr;
  assign d1_rdata = 32'hC000_0000 ^ d1_addr;

  fetch_ctrl dut0 (
    .clk(clk), .rst(rst), .PCsrc(pcsrc), .PCalu(pcalu), .stall(stall),
    .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
    .inst(inst), .inst_valid(iv), .pc_out(pco)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut1 (
    .clk(clk), .rst(d1_rst), .PCsrc(d1_pcsrc), .PCalu(d1_pcalu), .stall(d1_stall),
    .imem_req(d1_req), .imem_addr(d1_addr), .imem_ack(d1_ack), .imem_rdata(d1_rdata),
    .inst(d1_inst), .inst_valid(d1_iv), .pc_out(d1_pco)
  );

  typedef struct {
    logic        rst;
    logic        pcsrc;
    logic [31:0] pcalu;
    logic        stall;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic        cd;      // check inst/pc_out this row
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl [NV];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] r(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic d1_cycle(input int row, input logic r_i, input logic a_i,
                          input logic e_req, input logic [31:0] e_addr,
                          input logic e_iv, input logic cd,
                          input logic [31:0] e_inst, input logic [31:0] e_pc);
    @(negedge clk);
    d1_rst = r_i;
    d1_ack = a_i;
    #1;
    check("d1_req", row, {31'b0, d1_req}, {31'b0, e_req});
    if (e_req) check("d1_addr", row, d1_addr, e_addr);
    check("d1_inst_valid", row, {31'b0, d1_iv}, {31'b0, e_iv});
    if (cd) begin
      check("d1_inst", row, d1_inst, e_inst);
      check("d1_pc_out", row, d1_pco, e_pc);
    end
  endtask

  initial begin
    //        rst pcs pcalu          stl ack  req addr          iv cd inst         pc_out
    // reset
    tbl[0]  = '{1, 0, 32'h0,         0, 0,   0, 32'h0,         0, 1, 32'h0,       32'h0};
    // zero-wait streaming 0,4,8,C
    tbl[1]  = '{0, 0, 32'h0,         0, 1,   1, 32'h0,         0, 0, 32'h0,       32'h0};
    tbl[2]  = '{0, 0, 32'h0,         0, 1,   1, 32'h4,         1, 1, r(32'h0),    32'h0};
    tbl[3]  = '{0, 0, 32'h0,         0, 1,   1, 32'h8,         1, 1, r(32'h4),    32'h4};
    tbl[4]  = '{0, 0, 32'h0,         0, 1,   1, 32'hC,         1, 1, r(32'h8),    32'h8};
    // two wait states per request
    tbl[5]  = '{0, 0, 32'h0,         0, 0,   1, 32'h10,        1, 1, r(32'hC),    32'hC};
    tbl[6]  = '{0, 0, 32'h0,         0, 0,   1, 32'h10,        0, 0, 32'h0,       32'h0};
    tbl[7]  = '{0, 0, 32'h0,         0, 1,   1, 32'h10,        0, 0, 32'h0,       32'h0};
    tbl[8]  = '{0, 0, 32'h0,         0, 0,   1, 32'h14,        1, 1, r(32'h10),   32'h10};
    tbl[9]  = '{0, 0, 32'h0,         0, 0,   1, 32'h14,        0, 0, 32'h0,       32'h0};
    tbl[10] = '{0, 0, 32'h0,         0, 1,   1, 32'h14,        0, 0, 32'h0,       32'h0};
    // stall 3 cycles with a live instruction, then release
    tbl[11] = '{0, 0, 32'h0,         1, 0,   0, 32'h0,         1, 1, r(32'h14),   32'h14};
    tbl[12] = '{0, 0, 32'h0,         1, 0,   0, 32'h0,         1, 1, r(32'h14),   32'h14};
    tbl[13] = '{0, 0, 32'h0,         1, 0,   0, 32'h0,         1, 1, r(32'h14),   32'h14};
    tbl[14] = '{0, 0, 32'h0,         0, 0,   0, 32'h0,         1, 1, r(32'h14),   32'h14};
    tbl[15] = '{0, 0, 32'h0,         0, 1,   1, 32'h18,        0, 0, 32'h0,       32'h0};
    tbl[16] = '{0, 0, 32'h0,         0, 1,   1, 32'h1C,        1, 1, r(32'h18),   32'h18};
    // redirect to unaligned 5; ack in the same cycle is discarded
    tbl[17] = '{0, 1, 32'h5,         0, 1,   0, 32'h0,         1, 1, r(32'h1C),   32'h1C};
    tbl[18] = '{0, 0, 32'h0,         0, 0,   0, 32'h0,         0, 0, 32'h0,       32'h0};
    tbl[19] = '{0, 0, 32'h0,         0, 1,   1, 32'h5,         0, 0, 32'h0,       32'h0};
    tbl[20] = '{0, 0, 32'h0,         0, 1,   1, 32'h9,         1, 1, r(32'h5),    32'h5};
    tbl[21] = '{0, 0, 32'h0,         0, 0,   1, 32'hD,         1, 1, r(32'h9),    32'h9};
    // redirect + stall while in HOLD, then re-redirect during FLUSH
    tbl[22] = '{0, 0, 32'h0,         0, 1,   1, 32'hD,         0, 0, 32'h0,       32'h0};
    tbl[23] = '{0, 0, 32'h0,         1, 0,   0, 32'h0,         1, 1, r(32'hD),    32'hD};
    tbl[24] = '{0, 1, 32'h100,       1, 0,   0, 32'h0,         1, 1, r(32'hD),    32'hD};
    tbl[25] = '{0, 1, 32'h200,       0, 0,   0, 32'h0,         0, 0, 32'h0,       32'h0};
    tbl[26] = '{0, 0, 32'h0,         0, 0,   0, 32'h0,         0, 0, 32'h0,       32'h0};
    tbl[27] = '{0, 0, 32'h0,         0, 1,   1, 32'h200,       0, 0, 32'h0,       32'h0};
    tbl[28] = '{0, 0, 32'h0,         0, 0,   1, 32'h204,       1, 1, r(32'h200),  32'h200};
    // reset together with a redirect while a request is waiting
    tbl[29] = '{1, 1, 32'h300,       0, 0,   0, 32'h0,         0, 0, 32'h0,       32'h0};
    tbl[30] = '{0, 0, 32'h0,         0, 1,   1, 32'h0,         0, 1, 32'h0,       32'h0};
    tbl[31] = '{0, 0, 32'h0,         0, 0,   1, 32'h4,         1, 1, r(32'h0),    32'h0};

    rst = 1; pcsrc = 0; pcalu = 0; stall = 0; ack = 0;
    d1_rst = 1; d1_pcsrc = 0; d1_pcalu = 0; d1_stall = 0; d1_ack = 0;
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst   = tbl[i].rst;
      pcsrc = tbl[i].pcsrc;
      pcalu = tbl[i].pcalu;
      stall = tbl[i].stall;
      ack   = tbl[i].ack;
      #1;
      check("imem_req", i, {31'b0, req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) check("imem_addr", i, addr, tbl[i].e_addr);
      check("inst_valid", i, {31'b0, iv}, {31'b0, tbl[i].e_iv});
      if (tbl[i].cd) begin
        check("inst", i, inst, tbl[i].e_inst);
        check("pc_out", i, pco, tbl[i].e_pc);
      end
    end

    // Wrap-around instance: FFFF_FFF8, FFFF_FFFC, 0, then reset mid-wait.
    d1_cycle(100, 1, 0, 0, 32'h0,         0, 1, 32'h0,            32'h0);
    d1_cycle(101, 0, 1, 1, 32'hFFFF_FFF8, 0, 0, 32'h0,            32'h0);
    d1_cycle(102, 0, 1, 1, 32'hFFFF_FFFC, 1, 1, r(32'hFFFF_FFF8), 32'hFFFF_FFF8);
    d1_cycle(103, 0, 1, 1, 32'h0,         1, 1, r(32'hFFFF_FFFC), 32'hFFFF_FFFC);
    d1_cycle(104, 0, 0, 1, 32'h4,         1, 1, r(32'h0),         32'h0);
    d1_cycle(105, 0, 0, 1, 32'h4,         0, 0, 32'h0,            32'h0);
    d1_cycle(106, 1, 0, 0, 32'h0,         0, 0, 32'h0,            32'h0);
    d1_cycle(107, 0, 0, 1, 32'hFFFF_FFF8, 0, 1, 32'h0,            32'h0);
    d1_cycle(108, 0, 1, 1, 32'hFFFF_FFF8, 0, 0, 32'h0,            32'h0);
    d1_cycle(109, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, r(32'hFFFF_FFF8), 32'hFFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
